alu_result_skid_buf: RTL and testbench
======================================

// Module: alu_result_skid_buf
// PURPOSE
//  Downstream of the EX-stage adder: captures the 64-bit adder result plus
//  writeback tag and hands it to the EX/MEM boundary over valid/ready.
//  Applies RV64 word-op (ADDW/SUBW) sign extension and produces a zero flag.
//  2-entry skid buffer: full throughput, registered in_ready, no comb path in->out.
// PARAMETERS
//  XLEN   64  datapath width
//  RD_W   5   destination register index width
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     async reset, active-high
//  in_valid    in   1     adder result valid
//  in_ready    out  1     buffer can accept (registered)
//  in_result   in   XLEN  raw adder result_out
//  in_word     in   1     1 = word op: sign-extend bit 31 to XLEN
//  in_rd       in   RD_W  destination register
//  in_wen      in   1     register write enable
//  flush       in   1     sync squash of all held entries
//  out_valid   out  1     head entry valid
//  out_ready   in   1     downstream accepts
//  out_result  out  XLEN  head result (already extended)
//  out_rd      out  RD_W  head destination
//  out_wen     out  1     head write enable (0 when rd==0)
//  out_zero    out  1     head result == 0
// BEHAVIOUR
//  Reset: out_valid=0, in_ready=1, out_result=0, out_rd=0, out_wen=0, out_zero=1.
//  in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  Store rule: result = in_word ? {{32{in_result[31]}}, in_result[31:0]} : in_result;
//   wen stored as in_wen & (in_rd != 0); zero computed from stored result.
//  Slots: MAIN drives out_*; SKID holds overflow. FSM on occupancy:
//   EMPTY: in_fire -> MAIN, ->ONE.
//   ONE:   in_fire & out_fire -> MAIN replaced, stay ONE;
//          in_fire & !out_fire -> SKID, ->TWO; !in_fire & out_fire -> EMPTY.
//   TWO:   in_ready=0; out_fire -> SKID moves to MAIN, ->ONE.
//  in_ready next = !(next state == TWO). Never accepts while TWO.
//  Latency 1 cycle in_fire -> out_valid; 1 result/cycle sustained; strict FIFO order.
//  out_* held stable while out_valid & !out_ready.
//  flush: next state EMPTY, in_ready=1; same-cycle in_fire is dropped; wins over out_fire
//   (out_fire in that cycle still completes downstream; buffer does not re-present it).
//  Data fields of empty slots don't-care to bench except out_* after reset.
//  Async rst mid-transfer: all entries discarded, outputs to reset values immediately.
// STRUCTURE
//  Shared package (npc_pkg): XLEN, RD_W, occupancy encodings EMPTY=2'd0, ONE=2'd1,
//  TWO=2'd2, word-extend helper function.
//  One sub-module: alu_result_slot (register of {result,rd,wen,zero}, load enable,
//  async reset) instantiated twice as MAIN and SKID. Top holds FSM and muxing.
// TESTING
//  1 single: in 0x0000_0000_0000_0005,rd=3,wen=1, out_ready=1 -> next cycle out_valid,
//    out_result=5, out_wen=1, out_zero=0; following cycle out_valid=0.
//  2 word op: in_result=0x0000_0000_8000_0000,in_word=1 -> out_result=0xFFFF_FFFF_8000_0000;
//    in_result=0xFFFF_FFFF_0000_0000,in_word=1 -> out_result=0, out_zero=1.
//  3 backpressure: out_ready=0, push A,B -> in_ready=0 after B; C held off; raise
//    out_ready -> A,B,C emerge in order, one per cycle, none lost or duplicated.
//  4 x0: rd=0,wen=1,result=0x1234 -> out_wen=0, out_result=0x1234.
//  5 flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped entry absent.
//  6 rst asserted mid-stream, async w.r.t. clk -> out_valid=0, in_ready=1 before next edge.

Source files
------------

// File: rtl/npc_pkg.sv
// ---------------------------------------------------------------------------
// npc_pkg
// Shared definitions for the EX-stage result skid buffer.
//   XLEN        datapath width
//   RD_W        destination register index width
//   occ_t       buffer occupancy encoding (EMPTY / ONE / TWO)
//   word_extend RV64 word-op sign extension of a raw adder result
// ---------------------------------------------------------------------------
package npc_pkg;

    localparam int XLEN = 64;
    localparam int RD_W = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // ADDW/SUBW produce a 32-bit result that is sign-extended from bit 31.
    function automatic logic [XLEN-1:0] word_extend(input logic [XLEN-1:0] raw,
                                                    input logic            word);
        return word ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
    endfunction

endpackage

// File: rtl/alu_result_slot.sv
// ---------------------------------------------------------------------------
// alu_result_slot
// One storage entry of the result buffer: {result, rd, wen, zero}.
// Ports:
//   clk, rst        clock / async active-high reset
//   load            capture d_* on the rising edge
//   d_result/d_rd/d_wen/d_zero   entry to capture
//   q_result/q_rd/q_wen/q_zero   held entry (reset: 0 / 0 / 0 / 1)
// ---------------------------------------------------------------------------
module alu_result_slot
    import npc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] d_result,
    input  logic [RD_W-1:0] d_rd,
    input  logic            d_wen,
    input  logic            d_zero,
    output logic [XLEN-1:0] q_result,
    output logic [RD_W-1:0] q_rd,
    output logic            q_wen,
    output logic            q_zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_result <= '0;
            q_rd     <= '0;
            q_wen    <= 1'b0;
            q_zero   <= 1'b1;   // reset result is 0, so the flag agrees with it
        end else if (load) begin
            q_result <= d_result;
            q_rd     <= d_rd;
            q_wen    <= d_wen;
            q_zero   <= d_zero;
        end
    end

endmodule

// File: rtl/alu_result_skid_buf.sv
// ---------------------------------------------------------------------------
// alu_result_skid_buf
// Two-entry skid buffer between the EX-stage adder and the EX/MEM boundary.
// Applies word-op sign extension, suppresses writes to x0 and produces a zero
// flag on capture. in_ready is registered; there is no comb path in -> out.
// Ports:
//   clk, rst                    clock / async active-high reset
//   in_valid, in_ready          upstream handshake (in_ready registered)
//   in_result, in_word          raw adder result, word-op select
//   in_rd, in_wen               destination register and write enable
//   flush                       synchronous squash of all held entries
//   out_valid, out_ready        downstream handshake
//   out_result, out_rd          head entry (result already extended)
//   out_wen, out_zero           head write enable (0 for x0), result == 0
//
// state | meaning
// ------+---------------------------------------------------------
// EMPTY | no entry held; out_valid = 0
// ONE   | MAIN holds the head entry; SKID free
// TWO   | MAIN holds the head, SKID holds the next; in_ready = 0
// ---------------------------------------------------------------------------
module alu_result_skid_buf
    import npc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_word,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_wen,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic            out_zero
);

    occ_t state, state_nxt;

    logic in_fire, out_fire;
    logic main_load, skid_load, main_from_skid;

    logic [XLEN-1:0] in_ext;
    logic            in_wen_eff;
    logic            in_zero;

    logic [XLEN-1:0] skid_result;
    logic [RD_W-1:0] skid_rd;
    logic            skid_wen;
    logic            skid_zero;

    logic [XLEN-1:0] main_d_result;
    logic [RD_W-1:0] main_d_rd;
    logic            main_d_wen;
    logic            main_d_zero;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    assign in_ext     = word_extend(in_result, in_word);
    assign in_wen_eff = in_wen & (in_rd != '0);
    assign in_zero    = (in_ext == '0);

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_load = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    skid_load = 1'b1;
                    state_nxt = TWO;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush discards everything, including a same-cycle input.
        if (flush) begin
            state_nxt = EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != TWO);
            out_valid <= (state_nxt != EMPTY);
        end
    end

    assign main_d_result = main_from_skid ? skid_result : in_ext;
    assign main_d_rd     = main_from_skid ? skid_rd     : in_rd;
    assign main_d_wen    = main_from_skid ? skid_wen    : in_wen_eff;
    assign main_d_zero   = main_from_skid ? skid_zero   : in_zero;

    alu_result_slot u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .d_result (main_d_result),
        .d_rd     (main_d_rd),
        .d_wen    (main_d_wen),
        .d_zero   (main_d_zero),
        .q_result (out_result),
        .q_rd     (out_rd),
        .q_wen    (out_wen),
        .q_zero   (out_zero)
    );

    alu_result_slot u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load),
        .d_result (in_ext),
        .d_rd     (in_rd),
        .d_wen    (in_wen_eff),
        .d_zero   (in_zero),
        .q_result (skid_result),
        .q_rd     (skid_rd),
        .q_wen    (skid_wen),
        .q_zero   (skid_zero)
    );

endmodule

// File: tb/tb_alu_result_skid_buf.sv
// ---------------------------------------------------------------------------
// tb_alu_result_skid_buf
// Directed and randomized stimulus for alu_result_skid_buf against a queue
// model of the buffer contents. Inputs change and outputs are checked on the
// falling edge; the DUT samples on the rising edge.
// ---------------------------------------------------------------------------
module tb_alu_result_skid_buf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_result;
    logic        in_word;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_zero;

    alu_result_skid_buf dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_word    (in_word),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .out_zero   (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        logic        wen;
    } entry_t;

    entry_t      model_q[$];
    logic [63:0] popped[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, model_q.size() > 0);
        chk("in_ready", in_ready, model_q.size() < 2);
        if (model_q.size() > 0) begin
            chk("out_result", out_result, model_q[0].res);
            chk("out_rd", out_rd, model_q[0].rd);
            chk("out_wen", out_wen, model_q[0].wen);
            chk("out_zero", out_zero, model_q[0].res == 64'd0);
        end
    endtask

    // One clock: called right after a falling edge, returns at the next one.
    task automatic step(input logic iv, input logic [63:0] res, input logic word,
                        input logic [4:0] rd, input logic wen, input logic fl,
                        input logic ordy);
        entry_t e;
        logic   infire, outfire;
        in_valid  = iv;
        in_result = res;
        in_word   = word;
        in_rd     = rd;
        in_wen    = wen;
        flush     = fl;
        out_ready = ordy;
        check_outputs();
        infire  = iv && (model_q.size() < 2);
        outfire = ordy && (model_q.size() > 0);
        e.res = word ? 64'($signed(res[31:0])) : res;
        e.rd  = rd;
        e.wen = wen && (rd != 5'd0);
        @(posedge clk);
        if (outfire) popped.push_back(model_q[0].res);
        if (fl) begin
            model_q.delete();
        end else begin
            if (outfire) void'(model_q.pop_front());
            if (infire) model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        logic [63:0] r;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_result = '0;
        in_word   = 1'b0;
        in_rd     = '0;
        in_wen    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_rd", out_rd, 5'd0);
        chk("rst_out_wen", out_wen, 1'b0);
        chk("rst_out_zero", out_zero, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // single transfer
        step(1'b1, 64'd5, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        chk("single_valid", out_valid, 1'b1);
        chk("single_result", out_result, 64'd5);
        chk("single_wen", out_wen, 1'b1);
        chk("single_zero", out_zero, 1'b0);
        idle(1'b1);
        chk("single_drained", out_valid, 1'b0);

        // word ops
        step(1'b1, 64'h0000_0000_8000_0000, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1);
        chk("word_neg", out_result, 64'hFFFF_FFFF_8000_0000);
        step(1'b1, 64'hFFFF_FFFF_0000_0000, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
        chk("word_zero_res", out_result, 64'd0);
        chk("word_zero_flag", out_zero, 1'b1);
        idle(1'b1);

        // backpressure: A, B fill the buffer, C held off
        popped.delete();
        step(1'b1, 64'hA, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'hB, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("bp_full_ready", in_ready, 1'b0);
        step(1'b1, 64'hC, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("bp_held_ready", in_ready, 1'b0);
        step(1'b1, 64'hC, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        step(1'b1, 64'hC, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("bp_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("bp_order0", popped[0], 64'hA);
            chk("bp_order1", popped[1], 64'hB);
            chk("bp_order2", popped[2], 64'hC);
        end

        // write to x0 suppressed
        step(1'b1, 64'h1234, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("x0_wen", out_wen, 1'b0);
        chk("x0_result", out_result, 64'h1234);
        idle(1'b1);

        // flush while full with in_valid high
        step(1'b1, 64'hD, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'hE, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'hF, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        step(1'b1, 64'h77, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("flush_next_head", out_result, 64'h77);
        idle(1'b1);

        // async reset mid-stream
        step(1'b1, 64'h11, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 64'h22, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_out_result", out_result, 64'd0);
        chk("arst_out_zero", out_zero, 1'b1);
        model_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) r = 64'd0;
            if ($urandom_range(0, 7) == 0) r = {32'h1234_5678, 32'd0};
            step(1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
                 1'($urandom_range(0, 2) != 0));
        end
        repeat (3) idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
